// File: rtl/multicycle_cpu_pkg.sv
// multicycle_cpu_pkg: opcodes, FSM states, field widths and per-opcode access decode.
// Optional feature macro: MULTICYCLE_CPU_MUL_EN (MUL/MULi; NOPs when undefined).
`default_nettype none

package multicycle_cpu_pkg;

    localparam int OPC_W   = 4;
    localparam int STATE_W = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD     = 4'd0,
        OP_ADD_I   = 4'd1,
        OP_NAND    = 4'd2,
        OP_NAND_I  = 4'd3,
        OP_SRL     = 4'd4,
        OP_SRL_I   = 4'd5,
        OP_LT      = 4'd6,
        OP_LT_I    = 4'd7,
        OP_CP      = 4'd8,
        OP_CP_I    = 4'd9,
        OP_CPIND   = 4'd10,
        OP_CPIND_I = 4'd11,
        OP_BZJ     = 4'd12,
        OP_BZJ_I   = 4'd13,
        OP_MUL     = 4'd14,
        OP_MUL_I   = 4'd15
    } opcode_e;

    // Encoding order matters: next_state picks the first needed state after cur.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_RD_A   = 3'd1,
        S_RD_B   = 3'd2,
        S_RD_I   = 3'd3,
        S_WRITE  = 3'd4,
        S_RETIRE = 3'd5
    } state_e;

    typedef struct packed {
        logic rd_a;
        logic rd_b;
        logic rd_i;
        logic wr;
    } need_t;

    function automatic need_t decode_needs(input opcode_e op);
        need_t n;
        n = '0;
        case (op)
            OP_ADD, OP_NAND, OP_SRL, OP_LT: begin
                n.rd_a = 1'b1; n.rd_b = 1'b1; n.wr = 1'b1;
            end
            OP_ADD_I, OP_NAND_I, OP_SRL_I, OP_LT_I: begin
                n.rd_a = 1'b1; n.wr = 1'b1;
            end
            OP_CP:      begin n.rd_b = 1'b1; n.wr = 1'b1; end
            OP_CP_I:    n.wr = 1'b1;
            OP_CPIND:   begin n.rd_b = 1'b1; n.rd_i = 1'b1; n.wr = 1'b1; end
            OP_CPIND_I: begin n.rd_a = 1'b1; n.rd_b = 1'b1; n.wr = 1'b1; end
            OP_BZJ:     begin n.rd_a = 1'b1; n.rd_b = 1'b1; end
            OP_BZJ_I:   n.rd_a = 1'b1;
`ifdef MULTICYCLE_CPU_MUL_EN
            OP_MUL:     begin n.rd_a = 1'b1; n.rd_b = 1'b1; n.wr = 1'b1; end
            OP_MUL_I:   begin n.rd_a = 1'b1; n.wr = 1'b1; end
`endif
            default:    n = '0;
        endcase
        return n;
    endfunction

    function automatic state_e next_state(input state_e cur, input need_t n);
        state_e s;
        s = S_RETIRE;
        if (n.wr   && (cur < S_WRITE)) s = S_WRITE;
        if (n.rd_i && (cur < S_RD_I))  s = S_RD_I;
        if (n.rd_b && (cur < S_RD_B))  s = S_RD_B;
        if (n.rd_a && (cur < S_RD_A))  s = S_RD_A;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_cpu_alu.sv
// multicycle_cpu_alu: combinational result for the write-back value of each opcode.
// Optional feature macro: MULTICYCLE_CPU_MUL_EN (multiplier present only when defined).
`default_nettype none

module multicycle_cpu_alu
    import multicycle_cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  opcode_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] y_o
);

    localparam int SW = DATA_W + 1;

    logic [SW-1:0]     w_s;
    logic [DATA_W-1:0] w_shift;

    assign w_s = {1'b0, b_i};

    // Shift amounts in [DATA_W, 2*DATA_W) turn into a left shift by s-DATA_W.
    always_comb begin
        w_shift = '0;
        if (w_s < SW'(DATA_W)) begin
            w_shift = a_i >> b_i;
        end else if (w_s < SW'(2 * DATA_W)) begin
            w_shift = a_i << (b_i - DATA_W'(DATA_W));
        end
    end

    always_comb begin
        y_o = b_i;
        case (op_i)
            OP_ADD,  OP_ADD_I:  y_o = a_i + b_i;
            OP_NAND, OP_NAND_I: y_o = ~(a_i & b_i);
            OP_SRL,  OP_SRL_I:  y_o = w_shift;
            OP_LT,   OP_LT_I:   y_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
`ifdef MULTICYCLE_CPU_MUL_EN
            OP_MUL,  OP_MUL_I:  y_o = a_i * b_i;
`endif
            default:            y_o = b_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: memory-to-memory multicycle CPU with a single req/ack memory port.
// Optional feature macro: MULTICYCLE_CPU_MUL_EN (MUL/MULi; NOPs when undefined).
`default_nettype none

module multicycle_cpu
    import multicycle_cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              retire
);

    if (OPC_W + 2 * ADDR_W > DATA_W) begin : g_width_check
        $error("multicycle_cpu: DATA_W must be at least 4+2*ADDR_W");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    opcode_e           w_op;
    opcode_e           w_ir_op;
    need_t             w_need;
    logic [ADDR_W-1:0] w_fld_a, w_fld_b, w_addr;
    logic [DATA_W-1:0] w_opnd, w_alu_y;
    logic              w_is_imm, w_done;

    // During FETCH the opcode is still on the read bus, not yet in ir_q.
    assign w_op    = (state_q == S_FETCH) ? opcode_e'(mem_rdata[DATA_W-1 -: OPC_W])
                                          : opcode_e'(ir_q[DATA_W-1 -: OPC_W]);
    assign w_ir_op = opcode_e'(ir_q[DATA_W-1 -: OPC_W]);
    assign w_need  = decode_needs(w_op);
    assign w_fld_a = ir_q[2*ADDR_W-1 -: ADDR_W];
    assign w_fld_b = ir_q[ADDR_W-1:0];

    assign w_is_imm = (w_ir_op == OP_ADD_I) || (w_ir_op == OP_NAND_I) || (w_ir_op == OP_SRL_I) ||
                      (w_ir_op == OP_LT_I)  || (w_ir_op == OP_CP_I)   || (w_ir_op == OP_MUL_I);
    assign w_opnd   = w_is_imm ? {{(DATA_W-ADDR_W){1'b0}}, w_fld_b} : b_q;

    multicycle_cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i (w_ir_op),
        .a_i  (a_q),
        .b_i  (w_opnd),
        .y_o  (w_alu_y)
    );

    always_comb begin
        w_addr = '0;
        case (state_q)
            S_FETCH: w_addr = pc_q;
            S_RD_A:  w_addr = w_fld_a;
            S_RD_B:  w_addr = w_fld_b;
            S_RD_I:  w_addr = b_q[ADDR_W-1:0];
            S_WRITE: w_addr = (w_ir_op == OP_CPIND_I) ? a_q[ADDR_W-1:0] : w_fld_a;
            default: w_addr = '0;
        endcase
    end

    // Gating with rst makes a reset abandon any pending access and ignore ack.
    assign mem_req   = !rst && (state_q != S_RETIRE);
    assign mem_we    = !rst && (state_q == S_WRITE);
    assign mem_addr  = rst ? '0 : w_addr;
    assign mem_wdata = (!rst && (state_q == S_WRITE)) ? w_alu_y : '0;
    assign pc        = rst ? '0 : pc_q;
    assign retire    = !rst && (state_q == S_RETIRE);
    assign w_done    = mem_req && mem_ack;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        if (w_done) begin
            state_d = next_state(state_q, w_need);
            case (state_q)
                S_FETCH:        ir_d = mem_rdata;
                S_RD_A:         a_d  = mem_rdata;
                S_RD_B, S_RD_I: b_d  = mem_rdata;
                default:        ;
            endcase
        end
        if (state_q == S_RETIRE) begin
            state_d = S_FETCH;
            case (w_ir_op)
                OP_BZJ:   pc_d = (b_q == '0) ? a_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
                OP_BZJ_I: pc_d = a_q[ADDR_W-1:0] + w_fld_b;
                default:  pc_d = pc_q + ADDR_W'(1);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the data word and instruction width.
REQ-002 SHALL have parameter ADDR_W, default 14, the memory word address width; elaboration fails unless 4+2*ADDR_W <= DATA_W.
REQ-003 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port mem_req, output, 1, memory access request.
REQ-006 SHALL have port mem_we, output, 1, write enable qualifying mem_req.
REQ-007 SHALL have port mem_addr, output, ADDR_W, word address.
REQ-008 SHALL have port mem_wdata, output, DATA_W, write data.
REQ-009 SHALL have port mem_rdata, input, DATA_W, read data, valid when mem_ack is high.
REQ-010 SHALL have port mem_ack, input, 1, access completion.
REQ-011 SHALL have port pc, output, ADDR_W, current program counter.
REQ-012 SHALL have port retire, output, 1, one-cycle pulse per completed instruction.

Function
REQ-013 SHALL decode each instruction as opcode = [DATA_W-1:DATA_W-4], A = [2*ADDR_W-1:ADDR_W], B = [ADDR_W-1:0].
REQ-014 SHALL complete an access on a rising edge where mem_req && mem_ack (ack may arrive in the same cycle as req); until then it holds mem_req, mem_we, mem_addr and mem_wdata stable.
REQ-015 SHALL sequence the FSM FETCH -> RD_A -> RD_B -> RD_I -> WRITE -> FETCH; any state not needed by an opcode is skipped; each state leaves only on access completion.
REQ-016 SHALL execute the following operations, where *X = mem[X] and i-forms use B zero-extended:
- ADD 0 / ADDi 1: *A = *A + *B / B, modulo 2^DATA_W.
- NAND 2 / NANDi 3: *A = ~(*A & *B / B).
- SRL 4 / SRLi 5: *A = *A >> s when s < DATA_W, *A << (s-DATA_W) when s < 2*DATA_W, else 0; s = *B / B.
- LT 6 / LTi 7: *A = (*A < *B / B, unsigned) ? 1 : 0.
- CP 8 / CPi 9: *A = *B / B.
- CPI 10: *A = *(*B).
- CPIi 11: *(*A) = *B.
- MUL 14 / MULi 15: *A = low DATA_W bits of *A * *B / B.
REQ-017 SHALL use low ADDR_W bits of any memory word used as an address or PC value.
REQ-018 SHALL execute BZJ 12 as pc = (*B == 0) ? *A : pc+1, with no write.
REQ-019 SHALL execute BZJi 13 as pc = *A + B (mod 2^ADDR_W), with no write.
REQ-020 SHALL advance pc by 1 (wrapping at 2^ADDR_W-1 -> 0) on completion of every non-branch instruction.
REQ-021 SHALL pulse retire in the cycle after the final access of the instruction completes.
REQ-022 SHALL hold mem_req low for exactly one cycle between instructions (the retire cycle).
REQ-023 SHALL produce minimum latencies with zero-wait memory: CPi 2 accesses, ADDi 3, ADD/CPIi 4, CPI 4, BZJ 3 (FETCH, RD_A, RD_B).

Reset
REQ-024 SHALL, while rst is high, force state FETCH, pc=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retire=0, and clear internal registers.
REQ-025 SHALL, when rst asserts mid-access, abandon that access (including any pending write) and ignore mem_ack until the first FETCH after release.
REQ-026 SHALL issue the first fetch, at address 0, in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL implement MUL/MULi per REQ-016 when MULTICYCLE_CPU_MUL_EN is defined.
REQ-028 SHALL, when MULTICYCLE_CPU_MUL_EN is undefined, execute MUL/MULi as NOP: fetch only, pc+1, retire, no write, and no multiplier in the design.

Structure
REQ-029 SHALL place the opcode localparams/enum, the state enum and the field-slice width constants in shared package multicycle_cpu_pkg.
REQ-030 SHALL implement the data path (add, nand, shift, compare, multiply, select) in one combinational sub-module multicycle_cpu_alu; FSM and memory handshake stay in the top.

Verification
REQ-031 SHALL verify ADD, zero-wait: mem[0]=ADD A=100 B=101, mem[100]=5, mem[101]=7 -> mem[100]=12, pc=1, retire once, 4 accesses.
REQ-032 SHALL verify wait states: same program, ack delayed 3 cycles per access -> identical result; mem_addr and mem_wdata stable while awaiting ack.
REQ-033 SHALL verify BZJ: mem[101]=0, mem[100]=20 -> pc=20; mem[101]=1 -> pc=1; no write either case.
REQ-034 SHALL verify CPI/CPIi: mem[101]=200, mem[200]=0xABCD, CPI A=100 B=101 -> mem[100]=0xABCD; CPIi A=101 B=102 with mem[102]=9 -> mem[200]=9.
REQ-035 SHALL verify SRL and wrap: SRLi *A=0x80000000, B=31 -> 1; B=33 -> 0; an instruction at pc=2^ADDR_W-1 wraps pc to 0.
REQ-036 SHALL verify reset mid-write and MUL: rst during pending write with ack held low -> no write, pc=0; MULi *A=6, B=7 -> 42 with MULTICYCLE_CPU_MUL_EN defined, *A unchanged without it.
